// File: rtl/packet_buffer_egress_arbiter.sv
// packet_buffer_egress_arbiter: round-robin egress scheduler that grants one
// buffer lane at a time and forwards exactly one packet per grant to a shared
// AXI4-Stream consumer. It generates tlast from the captured head length and
// pops the lane's length entry in the RELEASE cycle.
// Optional stall watchdog: define PACKET_BUFFER_EGRESS_ARB_TIMEOUT_EN.

// Per-lane ready gating: only the granted lane sees downstream ready.
module packet_buffer_egress_arbiter_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 3
) (
  input  logic             active,
  input  logic [IDX_W-1:0] grant,
  input  logic             ready,
  output logic             tready
);
  assign tready = active && (grant == IDX_W'(LANE)) && ready;
endmodule

module packet_buffer_egress_arbiter #(
  parameter int NUM_LANES             = 8,
  parameter int OUTPUT_WIDTH          = 8,
  parameter int LEN_WIDTH             = 11,
  parameter int LANE_SELECT_IDX_WIDTH = $clog2(NUM_LANES),
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_LANES-1:0]                   pkt_avail_i,
  input  logic [NUM_LANES-1:0][LEN_WIDTH-1:0]    pkt_len_i,
  output logic [NUM_LANES-1:0]                   pkt_done_o,
  input  logic [NUM_LANES-1:0][OUTPUT_WIDTH-1:0] lane_tdata_i,
  input  logic [NUM_LANES-1:0]                   lane_tvalid_i,
  output logic [NUM_LANES-1:0]                   lane_tready_o,
  output logic [OUTPUT_WIDTH-1:0]                m_tdata_o,
  output logic                                   m_tvalid_o,
  input  logic                                   m_tready_i,
  output logic                                   m_tlast_o,
  output logic [LANE_SELECT_IDX_WIDTH-1:0]       m_tlane_o,
  output logic                                   err_o
);
  localparam int IW = LANE_SELECT_IDX_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, RELEASE} state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr, grant, grant_nxt, win_idx;
  logic [IW:0]          cand;
  logic                 win_vld;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 streaming, forced, lane_vld, last_beat, beat_acc;

  // The rotating search and lane index math assume at least two lanes.
  if (NUM_LANES < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("packet_buffer_egress_arbiter: NUM_LANES >= 2 and TIMEOUT_CYCLES >= 1 required");
  end

  // Rotating first-set search over pkt_avail_i, starting at rr_ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_LANES)) cand = cand - (IW+1)'(NUM_LANES);
      if (!win_vld && pkt_avail_i[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Combinational mux from the granted lane; the lane skid buffers register it.
  assign streaming  = (state == STREAM);
  assign lane_vld   = lane_tvalid_i[grant];
  assign last_beat  = (remaining == LEN_WIDTH'(1));
  assign m_tvalid_o = streaming && (lane_vld || forced);
  assign m_tdata_o  = (streaming && !forced) ? lane_tdata_i[grant] : '0;
  assign m_tlast_o  = streaming && (last_beat || forced);
  assign m_tlane_o  = grant;
  assign beat_acc   = m_tvalid_o && m_tready_i;
  assign grant_nxt  = (grant == IW'(NUM_LANES-1)) ? '0 : grant + 1'b1;

  // The synthetic abort beat never consumes lane data, so lane readies drop.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    packet_buffer_egress_arbiter_lane #(.LANE(i), .IDX_W(IW)) u_lane (
      .active (streaming && !forced),
      .grant  (grant),
      .ready  (m_tready_i),
      .tready (lane_tready_o[i])
    );
  end

`ifdef PACKET_BUFFER_EGRESS_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_cnt;

  assign forced = streaming && (stall_cnt == SW'(TIMEOUT_CYCLES));

  // Stall watchdog: counts STREAM cycles with the granted lane empty, saturating at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i || !streaming || beat_acc) stall_cnt <= '0;
    else if (!lane_vld && !forced)       stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign forced = 1'b0;
`endif

  // Packet FSM: grant, stream one packet, then pop the length and advance the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      remaining  <= '0;
      pkt_done_o <= '0;
      err_o      <= 1'b0;
    end else begin
      pkt_done_o <= '0;
      err_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            grant     <= win_idx;
            remaining <= pkt_len_i[win_idx];
            if (pkt_len_i[win_idx] == '0) begin
              // Empty packet: report and pop without sending beats.
              state               <= RELEASE;
              err_o               <= 1'b1;
              pkt_done_o[win_idx] <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (beat_acc) begin
            remaining <= remaining - 1'b1;
            if (last_beat || forced) begin
              state             <= RELEASE;
              pkt_done_o[grant] <= 1'b1;
              err_o             <= forced;
            end
          end
        end
        RELEASE: begin
          rr_ptr <= grant_nxt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/packet_buffer_egress_arbiter.md
# packet_buffer_egress_arbiter

Round-robin egress scheduler for the packet buffer lanes. Each lane holds whole frames, already split into `OUTPUT_WIDTH` words behind its egress skid buffer. This block grants one lane at a time to a single shared downstream AXI4-Stream consumer, such as the frame parser or capture DMA. It forwards exactly one packet per grant, using the lane's head-packet length, and generates `tlast`. It then pops the lane's length entry and advances the round-robin pointer.

## Interface
- `NUM_LANES`, 8, number of buffer lanes arbitrated.
- `OUTPUT_WIDTH`, 8, lane and output data width in bits.
- `LEN_WIDTH`, 11, width of a packet length in beats (max 2047).
- `LANE_SELECT_IDX_WIDTH`, `$clog2(NUM_LANES)`, width of the lane index.
- `TIMEOUT_CYCLES`, 1024, stall watchdog limit; used only with the macro below.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `pkt_avail_i[NUM_LANES]`  in  1  lane holds at least one complete packet; `pkt_len_i` is valid.
- `pkt_len_i[NUM_LANES]`  in  `LEN_WIDTH`  beat count of the lane's head packet.
- `pkt_done_o[NUM_LANES]`  out  1  one-cycle pulse that pops the lane's head length.
- `lane_tdata_i[NUM_LANES]`  in  `OUTPUT_WIDTH`  lane egress data.
- `lane_tvalid_i[NUM_LANES]`  in  1  lane egress valid.
- `lane_tready_o[NUM_LANES]`  out  1  lane egress ready.
- `m_tdata_o`  out  `OUTPUT_WIDTH`  shared output data.
- `m_tvalid_o`  out  1  shared output valid.
- `m_tready_i`  in  1  shared output ready.
- `m_tlast_o`  out  1  last beat of packet.
- `m_tlane_o`  out  `LANE_SELECT_IDX_WIDTH`  source lane of the current beat.
- `err_o`  out  1  one-cycle pulse on a length-zero packet or a watchdog abort.

## Operation
- FSM states: IDLE, STREAM, RELEASE.
- IDLE:
  - Search `pkt_avail_i` starting at `rr_ptr`, wrapping modulo `NUM_LANES`. The first set lane wins.
  - On a win: register `grant` and load `remaining = pkt_len_i[grant]`.
  - If the length is nonzero, go to STREAM. If the length is 0, pulse `err_o` and go to RELEASE (no beats).
- STREAM:
  - `m_tdata_o = lane_tdata_i[grant]`; `m_tvalid_o = lane_tvalid_i[grant]`.
  - `lane_tready_o[grant] = m_tready_i`. All other `lane_tready_o` are 0.
  - `m_tlast_o = (remaining == 1)`; `m_tlane_o = grant`.
  - Beat accepted when `m_tvalid_o && m_tready_i`: decrement `remaining`.
  - Accepting the beat with `remaining == 1` moves to RELEASE.
- RELEASE:
  - `pkt_done_o[grant] = 1` for this single cycle.
  - `rr_ptr <= grant + 1`, wrapping to 0 after `NUM_LANES-1`.
  - Next state is IDLE.
  - The lane must update `pkt_avail_i`/`pkt_len_i` within this cycle, so a stale head is never re-granted.
- Outside STREAM: `m_tvalid_o`, `m_tlast_o` and all `lane_tready_o` are 0.
- The grant is never revoked mid-packet. Other lanes asserting avail have no effect until RELEASE.
- `pkt_avail_i` deasserting on the granted lane during STREAM is ignored; the length was already captured.

## Timing
- Reset values:
  - state IDLE, `rr_ptr=0`, `grant=0`, `remaining=0`.
  - all outputs 0: `pkt_done_o`, `m_tvalid_o`, `m_tlast_o`, `m_tlane_o`, `err_o`, `lane_tready_o`.
- Reset mid-packet: the next cycle is IDLE with no `pkt_done_o` pulse. The packet stays at the lane head and is resent in full.
- Arbitration latency: avail seen in IDLE at cycle N makes STREAM active at N+1. The first beat can transfer at N+1.
- Data path: combinational mux from the granted lane to `m_*`. No added latency; the lane skid buffers provide the registering.
- Inter-packet overhead: 2 idle cycles (RELEASE, IDLE) per packet. An L-beat packet with continuous ready occupies L+2 cycles.
- Handshake:
  - `m_tdata_o`/`m_tlast_o` stay stable while `m_tvalid_o && !m_tready_i`.
  - `remaining` changes only on an accepted beat.
- All state registers update on the `clk_i` rising edge. `pkt_done_o` and `err_o` are registered pulses.

## Configuration
- Macro: `PACKET_BUFFER_EGRESS_ARB_TIMEOUT_EN`.
- Defined:
  - A stall counter clears on each accepted beat and on entry to STREAM.
  - It increments each STREAM cycle with `lane_tvalid_i[grant]==0`.
  - When it reaches `TIMEOUT_CYCLES`, the block forces one beat with `m_tvalid_o=1`, `m_tlast_o=1`, `m_tdata_o=0`.
  - When that beat is accepted, it pulses `err_o` and goes to RELEASE (pops the packet).
- Undefined: no counter exists. STREAM waits indefinitely on a stalled lane, and `err_o` fires only for length 0.

## Test plan
- Lane 3 avail with len 3, `m_tready_i=1` -> beats 0xA1, 0xA2, 0xA3 on cycles N+1..N+3 with `m_tlane_o=3`. `m_tlast_o` is high on the third beat only. `pkt_done_o[3]` pulses at N+4.
- Lanes 0-7 all avail with len 1 -> grant order 0,1,…,7,0. Each packet takes 3 cycles.
- Len 4 with `m_tready_i` low for 5 cycles after beat 2 -> beat 3 data and `m_tvalid_o` are held. `m_tlast_o` asserts on beat 4 only, and exactly 4 beats transfer.
- Lane 5 len 0 -> `err_o` pulse and `pkt_done_o[5]` pulse. No `m_tvalid_o`; `rr_ptr` advances to 6.
- `rst_i` asserted after 2 of 6 beats -> all outputs 0 the next cycle with no `pkt_done_o`. The same lane is regranted from `rr_ptr=0` and all 6 beats are resent.
- With `PACKET_BUFFER_EGRESS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`, and the lane stalled after beat 1 of 10 -> after 16 cycles, one beat with `m_tlast_o=1`, data 0, then an `err_o` pulse and a `pkt_done_o` pulse.
